// File: rtl/bsg_cache_nb_sbuf_deep.sv
// Parametrised-depth store buffer for the non-blocking cache: FIFO of pending stores with
// age-ordered snoop outputs, tail coalescing and a registered byte-merged load bypass.
module bsg_cache_nb_sbuf_deep #(
  parameter int unsigned word_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned ways_p       = 4,
  parameter int unsigned els_p        = 4,
  parameter bit          coalesce_p   = 1'b1,
  localparam int unsigned WayW   = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int unsigned MaskW  = word_width_p / 8,
  localparam int unsigned EntryW = addr_width_p + word_width_p + MaskW + WayW,
  localparam int unsigned CntW   = $clog2(els_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [EntryW-1:0]             sbuf_entry_i,
  input  logic                          v_i,
  output logic                          ready_o,
  output logic [EntryW-1:0]             sbuf_entry_o,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [CntW-1:0]               count_o,
  input  logic [addr_width_p-1:0]       bypass_addr_i,
  input  logic                          bypass_v_i,
  output logic [word_width_p-1:0]       bypass_data_o,
  output logic [MaskW-1:0]              bypass_mask_o,
  output logic [els_p*addr_width_p-1:0] snoop_addr_o,
  output logic [els_p*WayW-1:0]         snoop_way_o,
  output logic [els_p-1:0]              snoop_valid_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned OffW = $clog2(MaskW);

  logic [addr_width_p-1:0] addr_q [els_p];
  logic [word_width_p-1:0] data_q [els_p];
  logic [MaskW-1:0]        mask_q [els_p];
  logic [WayW-1:0]         way_q  [els_p];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, last_idx;
  logic [CntW-1:0] count_q, count_d;
  logic [word_width_p-1:0] byp_data_q, byp_data_d, merged_data;
  logic [MaskW-1:0]        byp_mask_q, byp_mask_d;

  logic [addr_width_p-1:0] in_addr;
  logic [word_width_p-1:0] in_data;
  logic [MaskW-1:0]        in_mask;
  logic [WayW-1:0]         in_way;
  logic merge_cand, merge_hit, enq, deq, accept;

  function automatic logic [PtrW-1:0] wrap_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Physical slot holding the i-th oldest entry.
  function automatic logic [PtrW-1:0] age_idx(logic [PtrW-1:0] h, int unsigned i);
    int unsigned s;
    s = 32'(h) + i;
    if (s >= els_p) s = s - els_p;
    return PtrW'(s);
  endfunction

  function automatic logic word_eq(logic [addr_width_p-1:0] a, logic [addr_width_p-1:0] b);
    return a[addr_width_p-1:OffW] == b[addr_width_p-1:OffW];
  endfunction

  assign in_way  = sbuf_entry_i[WayW-1:0];
  assign in_mask = sbuf_entry_i[WayW +: MaskW];
  assign in_data = sbuf_entry_i[WayW+MaskW +: word_width_p];
  assign in_addr = sbuf_entry_i[WayW+MaskW+word_width_p +: addr_width_p];

  assign last_idx = (tail_q == '0) ? PtrW'(els_p - 1) : tail_q - 1'b1;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(els_p));
  assign v_o     = ~empty_o;
  assign count_o = count_q;

  assign merge_cand = coalesce_p && v_i && !empty_o && word_eq(addr_q[last_idx], in_addr)
                      && (way_q[last_idx] == in_way);
  assign merge_hit  = merge_cand && !((count_q == CntW'(1)) && yumi_i);
  // A full buffer holds at least two entries, so the yumi term of merge_hit cannot matter here.
  assign ready_o    = ~full_o | merge_cand;
  assign accept     = v_i & ready_o;
  assign enq        = accept & ~merge_hit;
  assign deq        = yumi_i & v_o;

  assign sbuf_entry_o = {addr_q[head_q], data_q[head_q], mask_q[head_q], way_q[head_q]};

  always_comb begin
    head_d  = deq ? wrap_inc(head_q) : head_q;
    tail_d  = enq ? wrap_inc(tail_q) : tail_q;
    count_d = count_q;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
  end

  always_comb begin
    merged_data = data_q[last_idx];
    for (int unsigned b = 0; b < MaskW; b++) begin
      if (in_mask[b]) merged_data[8*b +: 8] = in_data[8*b +: 8];
    end
  end

  // Oldest to youngest, then the accepted incoming store; later writers win per lane.
  always_comb begin
    byp_data_d = '0;
    byp_mask_d = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      if (i < 32'(count_q) && word_eq(addr_q[age_idx(head_q, i)], bypass_addr_i)) begin
        for (int unsigned b = 0; b < MaskW; b++) begin
          if (mask_q[age_idx(head_q, i)][b]) begin
            byp_data_d[8*b +: 8] = data_q[age_idx(head_q, i)][8*b +: 8];
          end
        end
        byp_mask_d = byp_mask_d | mask_q[age_idx(head_q, i)];
      end
    end
    if (accept && word_eq(in_addr, bypass_addr_i)) begin
      for (int unsigned b = 0; b < MaskW; b++) begin
        if (in_mask[b]) byp_data_d[8*b +: 8] = in_data[8*b +: 8];
      end
      byp_mask_d = byp_mask_d | in_mask;
    end
  end

  always_comb begin
    snoop_addr_o  = '0;
    snoop_way_o   = '0;
    snoop_valid_o = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      snoop_addr_o[i*addr_width_p +: addr_width_p] = addr_q[age_idx(head_q, i)];
      snoop_way_o[i*WayW +: WayW]                  = way_q[age_idx(head_q, i)];
      snoop_valid_o[i]                             = (i < 32'(count_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (bypass_v_i) begin
        byp_data_q <= byp_data_d;
        byp_mask_q <= byp_mask_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (enq) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
        mask_q[tail_q] <= in_mask;
        way_q[tail_q]  <= in_way;
      end else if (merge_hit) begin
        data_q[last_idx] <= merged_data;
        mask_q[last_idx] <= mask_q[last_idx] | in_mask;
      end
    end
  end

  assign bypass_data_o = byp_data_q;
  assign bypass_mask_o = byp_mask_q;

  yumi_without_head: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted while no head entry is valid");

endmodule

// File: tb/tb_bsg_cache_nb_sbuf_deep.sv
// Randomised and directed bench for bsg_cache_nb_sbuf_deep: queue-based reference model,
// with dequeued entries and bypass results checked by a separate monitor process.
module tb_bsg_cache_nb_sbuf_deep;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  way;
  } ent_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } byp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  ent_t        sbuf_entry_i = '0;
  logic        v_i = 1'b0, yumi_i = 1'b0, bypass_v_i = 1'b0;
  logic [15:0] bypass_addr_i = '0;
  logic        ready_o, v_o, empty_o, full_o;
  logic [53:0] sbuf_entry_o;
  logic [2:0]  count_o;
  logic [31:0] bypass_data_o;
  logic [3:0]  bypass_mask_o;
  logic [63:0] snoop_addr_o;
  logic [7:0]  snoop_way_o;
  logic [3:0]  snoop_valid_o;

  int checks = 0;
  int errors = 0;

  ent_t mq[$];
  ent_t exp_deq_q[$];
  byp_t exp_byp_q[$];

  always #5 clk = ~clk;

  bsg_cache_nb_sbuf_deep #(
    .word_width_p(32), .addr_width_p(16), .ways_p(4), .els_p(4), .coalesce_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .sbuf_entry_i(sbuf_entry_i), .v_i(v_i), .ready_o(ready_o),
    .sbuf_entry_o(sbuf_entry_o), .v_o(v_o), .yumi_i(yumi_i), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .bypass_addr_i(bypass_addr_i),
    .bypass_v_i(bypass_v_i), .bypass_data_o(bypass_data_o), .bypass_mask_o(bypass_mask_o),
    .snoop_addr_o(snoop_addr_o), .snoop_way_o(snoop_way_o), .snoop_valid_o(snoop_valid_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic [1:0] w);
    ent_t e;
    e.addr = a; e.data = d; e.mask = m; e.way = w;
    return e;
  endfunction

  function automatic logic same_word(input logic [15:0] a, input logic [15:0] b);
    return a[15:2] == b[15:2];
  endfunction

  // Lane-wise overlay: later stores to the same word overwrite earlier bytes.
  function automatic byp_t model_byp(input logic [15:0] ba, input logic inc, input ent_t e);
    byp_t r;
    r = '0;
    foreach (mq[k]) begin
      if (same_word(mq[k].addr, ba)) begin
        for (int b = 0; b < 4; b++) if (mq[k].mask[b]) r.data[8*b +: 8] = mq[k].data[8*b +: 8];
        r.mask = r.mask | mq[k].mask;
      end
    end
    if (inc && same_word(e.addr, ba)) begin
      for (int b = 0; b < 4; b++) if (e.mask[b]) r.data[8*b +: 8] = e.data[8*b +: 8];
      r.mask = r.mask | e.mask;
    end
    return r;
  endfunction

  task automatic check_state();
    logic [3:0] sv;
    int n;
    n = mq.size();
    chk("count", 64'(count_o), 64'(n));
    chk("empty", 64'(empty_o), 64'(n == 0));
    chk("full", 64'(full_o), 64'(n == 4));
    chk("v_o", 64'(v_o), 64'(n > 0));
    if (n > 0) chk("head_entry", 64'(sbuf_entry_o), 64'(mq[0]));
    sv = '0;
    for (int i = 0; i < 4; i++) if (i < n) sv[i] = 1'b1;
    chk("snoop_valid", 64'(snoop_valid_o), 64'(sv));
    for (int i = 0; i < n; i++) begin
      chk("snoop_addr", 64'(snoop_addr_o[i*16 +: 16]), 64'(mq[i].addr));
      chk("snoop_way", 64'(snoop_way_o[i*2 +: 2]), 64'(mq[i].way));
    end
  endtask

  // One clock cycle of stimulus; returns the sampled ready_o.
  task automatic step(input logic v, input ent_t e, input logic yumi, input logic bv,
                      input logic [15:0] ba, output logic rdy);
    int n;
    logic mc, exp_ready, merge;
    check_state();
    n = mq.size();
    if (n == 0) yumi = 1'b0;
    v_i = v; sbuf_entry_i = e; yumi_i = yumi; bypass_v_i = bv; bypass_addr_i = ba;
    #1;
    mc = v && n > 0 && same_word(mq[n-1].addr, e.addr) && mq[n-1].way == e.way;
    exp_ready = (n < 4) || mc;
    merge = mc && !(n == 1 && yumi);
    rdy = ready_o;
    chk("ready", 64'(ready_o), 64'(exp_ready));
    if (bv) exp_byp_q.push_back(model_byp(ba, v && exp_ready, e));
    if (v && exp_ready && merge) begin
      for (int b = 0; b < 4; b++) if (e.mask[b]) mq[n-1].data[8*b +: 8] = e.data[8*b +: 8];
      mq[n-1].mask = mq[n-1].mask | e.mask;
    end
    if (yumi) begin
      exp_deq_q.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (v && exp_ready && !merge) mq.push_back(e);
    @(posedge clk);
    #2;
    v_i = 1'b0; yumi_i = 1'b0; bypass_v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; bypass_v_i = 1'b0;
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    mq.delete();
  endtask

  task automatic drain();
    logic r;
    for (int k = 0; k < 8 && mq.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0, '0, r);
  endtask

  // Monitor: checks dequeued entries and registered bypass outputs.
  initial begin
    byp_t cur;
    logic pend;
    logic [31:0] bm;
    cur = '0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_byp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bypass_queue actual=empty required=entry");
        end else begin
          cur = exp_byp_q.pop_front();
        end
      end
      bm = {{8{cur.mask[3]}}, {8{cur.mask[2]}}, {8{cur.mask[1]}}, {8{cur.mask[0]}}};
      chk("bypass_mask", 64'(bypass_mask_o), 64'(cur.mask));
      chk("bypass_data", 64'(bypass_data_o & bm), 64'(cur.data & bm));
      if (reset_i) begin
        cur = '0;
        pend = 1'b0;
      end else begin
        pend = bypass_v_i;
        if (yumi_i && v_o) begin
          if (exp_deq_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL deq_queue actual=entry required=none");
          end else begin
            chk("deq_entry", 64'(sbuf_entry_o), 64'(exp_deq_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic r;
    do_reset();
    check_state();
    chk("rst_bypass_data", 64'(bypass_data_o), 64'h0);

    // First enqueue visible one edge later.
    step(1'b1, mk(16'h100, 32'hAABBCCDD, 4'hF, 2'd1), 1'b0, 1'b0, '0, r);
    chk("t1_v_o", 64'(v_o), 64'h1);
    chk("t1_count", 64'(count_o), 64'h1);
    chk("t1_snoop_valid", 64'(snoop_valid_o), 64'h1);
    chk("t1_snoop_addr0", 64'(snoop_addr_o[15:0]), 64'h100);
    drain();

    // Fill, then a non-merging store is refused even with a simultaneous pop.
    for (int i = 0; i < 4; i++) step(1'b1, mk(16'(i*4), $urandom, 4'hF, 2'd0), 1'b0, 1'b0, '0, r);
    chk("full_flag", 64'(full_o), 64'h1);
    step(1'b1, mk(16'h10, 32'h12345678, 4'hF, 2'd0), 1'b1, 1'b0, '0, r);
    chk("full_ready_yumi", 64'(r), 64'h0);
    step(1'b1, mk(16'h10, 32'h12345678, 4'hF, 2'd0), 1'b0, 1'b0, '0, r);
    chk("retry_ready", 64'(r), 64'h1);
    drain();

    // Coalescing into the tail entry.
    step(1'b1, mk(16'h20, 32'h00001122, 4'h3, 2'd0), 1'b0, 1'b0, '0, r);
    step(1'b1, mk(16'h22, 32'h33440000, 4'hC, 2'd0), 1'b0, 1'b0, '0, r);
    chk("merge_count", 64'(count_o), 64'h1);
    chk("merge_data", 64'(sbuf_entry_o[37:6]), 64'h33441122);
    chk("merge_mask", 64'(sbuf_entry_o[5:2]), 64'hF);
    drain();
    step(1'b1, mk(16'h20, 32'h00001122, 4'h3, 2'd0), 1'b0, 1'b0, '0, r);
    step(1'b1, mk(16'h22, 32'h33440000, 4'hC, 2'd1), 1'b0, 1'b0, '0, r);
    chk("nomerge_count", 64'(count_o), 64'h2);
    drain();

    // Bypass: youngest byte wins, incoming store included.
    step(1'b1, mk(16'h40, 32'h000000AA, 4'h1, 2'd0), 1'b0, 1'b0, '0, r);
    step(1'b1, mk(16'h40, 32'h000000BB, 4'h1, 2'd1), 1'b0, 1'b0, '0, r);
    step(1'b1, mk(16'h40, 32'h0000CC00, 4'h2, 2'd2), 1'b0, 1'b1, 16'h40, r);
    chk("byp_data", 64'(bypass_data_o[15:0]), 64'hCCBB);
    chk("byp_mask", 64'(bypass_mask_o), 64'h3);
    step(1'b0, '0, 1'b0, 1'b0, 16'h0, r);
    chk("byp_hold_data", 64'(bypass_data_o[15:0]), 64'hCCBB);
    chk("byp_hold_mask", 64'(bypass_mask_o), 64'h3);

    // Reset with three entries and a non-zero bypass.
    do_reset();
    chk("rst2_count", 64'(count_o), 64'h0);
    chk("rst2_v_o", 64'(v_o), 64'h0);
    chk("rst2_empty", 64'(empty_o), 64'h1);
    chk("rst2_full", 64'(full_o), 64'h0);
    chk("rst2_snoop_valid", 64'(snoop_valid_o), 64'h0);
    chk("rst2_byp_data", 64'(bypass_data_o), 64'h0);
    chk("rst2_byp_mask", 64'(bypass_mask_o), 64'h0);
    step(1'b1, mk(16'h200, 32'hCAFEF00D, 4'hF, 2'd3), 1'b0, 1'b0, '0, r);
    chk("rst2_accept", 64'(r), 64'h1);
    chk("rst2_count_after", 64'(count_o), 64'h1);
    drain();

    // Continuous push/pop across pointer wrap.
    step(1'b1, mk(16'h300, $urandom, 4'hF, 2'd0), 1'b0, 1'b0, '0, r);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, mk(16'(16'h300 + i*4), $urandom, 4'hF, 2'(i)), 1'b1, 1'b0, '0, r);
    end
    drain();

    // Random traffic on a small address window so merges and bypass hits are frequent.
    for (int i = 0; i < 400; i++) begin
      ent_t e;
      e = mk(16'(16'h80 + ($urandom % 4) * 4 + ($urandom % 4)), $urandom, 4'($urandom % 16),
             2'($urandom % 2));
      step(($urandom % 4) != 0, e, ($urandom % 3) == 0, 1'($urandom % 2),
           16'(16'h80 + ($urandom % 4) * 4 + ($urandom % 4)), r);
    end
    drain();
    check_state();
    repeat (3) @(posedge clk);
    chk("deq_queue_empty", 64'(exp_deq_q.size()), 64'h0);
    chk("byp_queue_empty", 64'(exp_byp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_cache_nb_sbuf_deep.md
Name: bsg_cache_nb_sbuf_deep

Overview:
- Parametrised-depth store buffer for the non-blocking cache.
- Holds els_p pending store entries {addr, data, mask, way_id} in FIFO order.
- Exposes every entry's address, way and valid bit in age order for hazard snooping.
- Supplies a registered byte-merged bypass word for loads, and optionally coalesces a store into the youngest entry when it hits the same word and way.

Parameters:
- word_width_p, none (required), data word width in bits; multiple of 8.
- addr_width_p, none (required), byte address width.
- ways_p, none (required), cache associativity; way_id width = safe_clog2(ways_p).
- els_p, 4, buffer depth; minimum 2.
- coalesce_p, 1, 1 enables same-word merging into the tail entry; 0 always allocates a new entry.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- sbuf_entry_i  in  E  store entry. E = addr_width_p + word_width_p + word_width_p/8 + way_id width, packed MSB to LSB as addr, data, mask, way_id.
- v_i  in  1  entry valid.
- ready_o  out  1  entry accepted this cycle when v_i & ready_o.
- sbuf_entry_o  out  E  oldest (head) entry.
- v_o  out  1  head valid.
- yumi_i  in  1  consumer takes the head; legal only while v_o=1.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == els_p.
- count_o  out  clog2(els_p+1)  number of valid entries.
- bypass_addr_i  in  addr_width_p  load byte address.
- bypass_v_i  in  1  capture bypass result this cycle.
- bypass_data_o  out  word_width_p  registered merged data.
- bypass_mask_o  out  word_width_p/8  registered merged byte mask.
- snoop_addr_o  out  els_p*addr_width_p  entry addresses; slot 0 = oldest.
- snoop_way_o  out  els_p*way_id width  entry way ids, same ordering.
- snoop_valid_o  out  els_p  slot valid; always a thermometer code from slot 0.

Behaviour:
- Reset: count 0; v_o=0, empty_o=1, full_o=0, snoop_valid_o=0, bypass_data_o=0, bypass_mask_o=0. Entry storage contents need no reset.
- Word match: addresses compared above the low clog2(word_width_p/8) bits.
- Merge hit: coalesce_p=1 AND v_i AND count>0 AND tail word address == incoming word address AND tail way == incoming way AND NOT (count==1 AND yumi_i).
- Merge action:
  - In tail data, bytes with incoming mask=1 are replaced by incoming bytes.
  - Tail mask |= incoming mask.
  - Tail address is unchanged; count is unchanged.
- ready_o = ~full_o | merge_hit. Combinational from state and v_i only; never from yumi_i. A full buffer does not accept a non-merging entry even when yumi_i=1 in the same cycle.
- Enqueue without merge: entry written to the tail slot; count+1 at the next edge.
- Simultaneous enqueue and dequeue: count unchanged; both take effect.
- Dequeue: yumi_i pops the head. sbuf_entry_o and v_o are valid in the same cycle as the write that made them valid becomes visible, i.e. one edge after acceptance; no combinational pass-through.
- Snoop outputs reflect the registered state only; incoming entries are excluded until the next edge.
- Bypass candidates, in priority from lowest to highest:
  - all valid entries, oldest to youngest;
  - then sbuf_entry_i, if v_i & ready_o.
- Bypass merging: for each byte lane, the youngest matching candidate with that mask bit set supplies the data. Merged mask = OR of the masks of all matching candidates.
- Lanes with merged mask 0 carry don't-care data; the bench checks only masked lanes.
- Entries dequeued in the same cycle still participate in the bypass.
- Bypass registering: bypass_data_o and bypass_mask_o update on the edge where bypass_v_i=1, giving 1-cycle latency. They hold their value when bypass_v_i=0.
- Pointer wrap: head and tail wrap modulo els_p. Snoop slot order is always by age, independent of physical position.
- Illegal conditions, flagged by assertions in simulation:
  - yumi_i while v_o=0;
  - v_i & ~ready_o is not an error; the producer retries.

Test Plan:
- Reset, then enqueue addr 0x100/data 0xAABBCCDD/mask 0xF/way 1 -> next cycle v_o=1, count_o=1, snoop_valid_o=4'b0001, snoop_addr slot0=0x100.
- Fill 4 distinct words (0x0, 0x4, 0x8, 0xC) -> full_o=1. A 5th store to 0x10 gets ready_o=0, including when yumi_i=1 in that cycle; the next cycle it is accepted.
- coalesce_p=1: store 0x20 mask 0x3 data 0x....1122, then 0x22 way equal mask 0xC data 0x3344.... -> count_o=1, head data 0x33441122, mask 0xF. The same pair with a different way -> count_o=2.
- Bypass: entries 0x40 mask 0x1 data 0x000000AA and 0x40 mask 0x1 data 0x000000BB (coalesce_p=0), plus incoming 0x40 mask 0x2 data 0x0000CC00, with bypass_v_i=1 -> next cycle data[15:0]=0xCCBB, mask=0x3. With bypass_v_i=0 on the following cycle the outputs hold.
- Wrap: push and pop 10 entries continuously with els_p=4 -> FIFO order is preserved; snoop slot 0 always equals sbuf_entry_o.addr; count_o is never above 4.
- Reset asserted with count_o=3 and bypass outputs non-zero -> next cycle all outputs are at their reset values; a new enqueue is accepted immediately.
